// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 32-bit RAM.
// Sub-word writes are done as read-modify-write so the RAM only sees whole words.
module ram_arbiter #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_valid,
    output logic          m0_ready,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wstrb,
    output logic [31:0]   m0_rdata,
    input  logic          m1_valid,
    output logic          m1_ready,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wstrb,
    output logic [31:0]   m1_rdata,
    output logic          ram_ce,
    output logic          ram_wre,
    output logic [AW-1:0] ram_ad,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout,
    output logic          ram_oce,
    output logic          ram_reset,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RMW_ISSUE, RMW_WAIT, RESP
    } state_t;

    state_t        state, state_nxt;
    logic          prio;      // 1: port 1 wins a tie
    logic          port;
    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;
    logic [3:0]    strb_q;
    logic [31:0]   rdata_q;
    logic [31:0]   merged;

    // Upper and byte-offset address bits alias onto the same word.
    logic unused_addr;
    assign unused_addr = &{1'b0, m0_addr[31:AW+2], m0_addr[1:0],
                           m1_addr[31:AW+2], m1_addr[1:0]};

    logic          any_req, sel1;
    logic [AW-1:0] req_word;
    logic [31:0]   req_wdata;
    logic [3:0]    req_strb;

    assign any_req   = m0_valid | m1_valid;
    assign sel1      = m1_valid & (~m0_valid | prio);
    assign req_word  = sel1 ? m1_addr[AW+1:2] : m0_addr[AW+1:2];
    assign req_wdata = sel1 ? m1_wdata : m0_wdata;
    assign req_strb  = sel1 ? m1_wstrb : m0_wstrb;

    always_comb begin
        merged = ram_dout;
        for (int i = 0; i < 4; i++)
            if (strb_q[i]) merged[8*i +: 8] = data_q[8*i +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ram_ce    = 1'b0;
        ram_wre   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (req_strb == 4'h0)      state_nxt = RD_ISSUE;
                    else if (req_strb == 4'hF) state_nxt = WR_ISSUE;
                    else                       state_nxt = RMW_ISSUE;
                end
            end
            RD_ISSUE: begin
                ram_ce    = 1'b1;
                state_nxt = RD_WAIT;
            end
            RD_WAIT:  state_nxt = RESP;
            WR_ISSUE: begin
                ram_ce    = 1'b1;
                ram_wre   = 1'b1;
                state_nxt = RESP;
            end
            RMW_ISSUE: begin
                ram_ce    = 1'b1;
                state_nxt = RMW_WAIT;
            end
            RMW_WAIT: state_nxt = WR_ISSUE;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio    <= 1'b0;
            port    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    port   <= sel1;
                    prio   <= ~sel1;
                    addr_q <= req_word;
                    data_q <= req_wdata;
                    strb_q <= req_strb;
                end
                RD_WAIT:  rdata_q <= ram_dout;
                RMW_WAIT: data_q  <= merged;
                default: ;
            endcase
        end
    end

    assign ram_ad    = addr_q;
    assign ram_din   = data_q;
    assign ram_oce   = 1'b1;
    assign ram_reset = reset;
    assign busy      = (state != IDLE);
    assign m0_ready  = (state == RESP) & ~port;
    assign m1_ready  = (state == RESP) & port;
    assign m0_rdata  = rdata_q;
    assign m1_rdata  = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, directed requests, and a scoreboard
// monitor that checks port, data, latency and RAM traffic at each ready pulse.
module tb_ram_arbiter;

    logic        clk, rst;
    logic        m0_valid, m1_valid, m0_ready, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        ram_ce, ram_wre, ram_oce, ram_reset, busy;
    logic [9:0]  ram_ad;
    logic [31:0] ram_din, ram_dout;

    ram_arbiter #(.AW(10)) dut (
        .clk(clk), .reset(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_oce(ram_oce), .ram_reset(ram_reset), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bypass-read RAM: dout appears the cycle after a read issue.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) mem[ram_ad] <= ram_din;
            else         ram_dout    <= mem[ram_ad];
        end
    end

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        logic [9:0]  ad;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0, checks = 0;
    int          cyc = 0;
    int          grant_cyc = 0, n_rd = 0, n_wr = 0, tot_wr = 0;
    logic [9:0]  last_ad = '0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: tracks grant cycle and RAM traffic, pops on every ready pulse.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (ram_ce) begin
            if (ram_wre) begin n_wr++; tot_wr++; end
            else n_rd++;
            last_ad = ram_ad;
        end
        if (rst) begin
            n_rd = 0; n_wr = 0;
        end else begin
            if (!busy && (m0_valid || m1_valid)) begin
                grant_cyc = cyc; n_rd = 0; n_wr = 0;
            end
            if (m0_ready || m1_ready) begin
                if (sbq.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
                else begin
                    e = sbq.pop_front();
                    chk("both_ready", 32'(m0_ready & m1_ready), 32'd0);
                    chk("ready_port", 32'(m1_ready), 32'(e.port));
                    chk("rdata", e.port ? m1_rdata : m0_rdata, e.rdata);
                    chk("latency", 32'(cyc - grant_cyc), 32'(e.lat));
                    chk("ram_reads", 32'(n_rd), 32'(e.nrd));
                    chk("ram_writes", 32'(n_wr), 32'(e.nwr));
                    chk("ram_ad", 32'(last_ad), 32'(e.ad));
                end
            end
        end
    end

    task automatic push_exp(input bit port, input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] exp_rd);
        exp_t e;
        e.port = port;
        if (strb == 4'h0) last_rd = exp_rd;
        e.rdata = last_rd;
        e.lat   = (strb == 4'h0) ? 3 : (strb == 4'hF) ? 2 : 4;
        e.nrd   = (strb == 4'hF) ? 0 : 1;
        e.nwr   = (strb == 4'h0) ? 0 : 1;
        e.ad    = addr[11:2];
        sbq.push_back(e);
    endtask

    // Drive one request and wait (bounded) for its ready; keep=1 leaves valid high.
    task automatic drive(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input bit keep);
        bit got = 0;
        @(posedge clk); #1;
        if (port) begin m1_addr = addr; m1_wdata = wdata; m1_wstrb = strb; m1_valid = 1'b1; end
        else      begin m0_addr = addr; m0_wdata = wdata; m0_wstrb = strb; m0_valid = 1'b1; end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = port ? m1_ready : m0_ready;
        end
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
        if (!keep) begin
            @(posedge clk); #1;
            if (port) m1_valid = 1'b0; else m0_valid = 1'b0;
        end
    endtask

    task automatic req(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] exp_rd);
        push_exp(port, addr, strb, exp_rd);
        drive(port, addr, wdata, strb, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
    endtask

    initial begin
        int wr_snap;
        rst = 1'b1;
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'({m0_ready, m1_ready}), 32'd0);
        chk("rst_ce_wre", 32'({ram_ce, ram_wre}), 32'd0);
        chk("rst_ad", 32'(ram_ad), 32'd0);
        chk("rst_din", ram_din, 32'd0);
        chk("rst_rdata", m0_rdata, 32'd0);
        chk("rst_oce_reset", 32'({ram_oce, ram_reset}), 32'b11);
        rst = 1'b0;

        // Seed words 1 and 2, then reset so contention starts with port 0 priority.
        req(0, 32'h4, 32'hAAAA0001, 4'hF, 32'h0);
        req(1, 32'h8, 32'hBBBB0002, 4'hF, 32'h0);
        do_reset();

        push_exp(0, 32'h4, 4'h0, 32'hAAAA0001);
        push_exp(1, 32'h8, 4'h0, 32'hBBBB0002);
        push_exp(0, 32'h4, 4'h0, 32'hAAAA0001);
        push_exp(1, 32'h8, 4'h0, 32'hBBBB0002);
        fork
            begin
                for (int i = 0; i < 2; i++) drive(0, 32'h4, 32'h0, 4'h0, i == 0);
            end
            begin
                for (int j = 0; j < 2; j++) drive(1, 32'h8, 32'h0, 4'h0, j == 0);
            end
        join

        req(0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
        req(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
        req(1, 32'h10, 32'h11223344, 4'b0101, 32'h0);
        req(1, 32'h10, 32'h0, 4'h0, 32'hDE22BE44);
        req(0, 32'h0000_1010, 32'h0, 4'h0, 32'hDE22BE44);
        req(0, 32'h8, 32'h77000000, 4'h8, 32'h0);
        req(1, 32'h8, 32'h0, 4'h0, 32'h77BB0002);

        // Reset while a partial write sits in RMW_WAIT.
        wr_snap = tot_wr;
        @(posedge clk); #1;
        m1_addr = 32'h10; m1_wdata = 32'h55555555; m1_wstrb = 4'b0011; m1_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        m1_valid = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ce_wre", 32'({ram_ce, ram_wre}), 32'd0);
        chk("midrst_ready", 32'({m0_ready, m1_ready}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        repeat (3) @(negedge clk);
        chk("midrst_no_write", 32'(tot_wr), 32'(wr_snap));
        chk("midrst_rdata", m1_rdata, 32'h0);
        req(1, 32'h10, 32'h0, 4'h0, 32'hDE22BE44);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
